// File: rtl/lcd_write_scheduler.sv
// rtl/lcd_write_scheduler.sv - HD44780 bus owner: power-up init, request arbitration, E timing, cursor tracking (optional macro LCD_CURSOR_TRACK_EN)
module lcd_write_scheduler #(
    parameter int POWERUP_CYC  = 20000,
    parameter int E_HIGH_CYC   = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 80000,
    parameter int CNT_W        = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p0_valid,
    output logic       p0_ready,
    input  logic       p0_row,
    input  logic [3:0] p0_col,
    input  logic [7:0] p0_char,
    input  logic       p1_valid,
    output logic       p1_ready,
    input  logic       p1_row,
    input  logic [3:0] p1_col,
    input  logic [7:0] p1_char,
    input  logic       clr_valid,
    output logic       clr_ready,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_ADDR,
        S_CHAR,
        S_CLEAR
    } state_t;

    // Transaction timeline on cnt: 0 = setup, 1..E_HIGH_CYC = E high, then the wait phase.
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LAST   = CNT_W'(E_HIGH_CYC);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(E_HIGH_CYC + CMD_WAIT_CYC);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(E_HIGH_CYC + CLR_WAIT_CYC);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       init_idx;
    logic             rr_p1;
    logic             row_q;
    logic [3:0]       col_q;
    logic [7:0]       char_q;

    logic             in_tx;
    logic             clr_cmd;
    logic             tx_last;
    logic             pwr_last;
    logic             init_last;
    logic             grant_clr;
    logic             grant_p0;
    logic             grant_p1;
    logic             sel_row;
    logic [3:0]       sel_col;
    logic [7:0]       sel_char;
    logic             need_addr;

    assign in_tx     = state inside {S_INIT, S_ADDR, S_CHAR, S_CLEAR};
    assign clr_cmd   = (state == S_CLEAR) || ((state == S_INIT) && (init_idx == 2'd3));
    assign tx_last   = in_tx && (cnt == (clr_cmd ? CLR_LAST : CMD_LAST));
    assign pwr_last  = (state == S_PWRUP) && (cnt == PWR_LAST);
    assign init_last = (state == S_INIT) && tx_last && (init_idx == 2'd3);

    // Clear wins; between the two writers the pointer gives the port not served last time priority.
    assign grant_clr = (state == S_IDLE) && clr_valid;
    assign grant_p0  = (state == S_IDLE) && !clr_valid && p0_valid && (!p1_valid || !rr_p1);
    assign grant_p1  = (state == S_IDLE) && !clr_valid && p1_valid && (!p0_valid || rr_p1);

    assign sel_row   = grant_p1 ? p1_row  : p0_row;
    assign sel_col   = grant_p1 ? p1_col  : p0_col;
    assign sel_char  = grant_p1 ? p1_char : p0_char;

`ifdef LCD_CURSOR_TRACK_EN
    logic       cur_row;
    logic [3:0] cur_col;
    logic       cur_valid;

    assign need_addr = !(cur_valid && (cur_row == sel_row) && (cur_col == sel_col));

    // Mirror the LCD's auto-incrementing address; writing column 15 leaves it unknown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_row   <= 1'b0;
            cur_col   <= 4'd0;
            cur_valid <= 1'b0;
        end else if (init_last || ((state == S_CLEAR) && tx_last)) begin
            cur_row   <= 1'b0;
            cur_col   <= 4'd0;
            cur_valid <= 1'b1;
        end else if ((state == S_CHAR) && tx_last) begin
            cur_row   <= row_q;
            cur_col   <= col_q + 4'd1;
            cur_valid <= (col_q != 4'hF);
        end
    end
`else
    assign need_addr = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_PWRUP;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            S_PWRUP: if (pwr_last) state_nx = S_INIT;
            S_INIT:  if (init_last) state_nx = S_IDLE;
            S_IDLE: begin
                if (grant_clr) begin
                    state_nx = S_CLEAR;
                end else if (grant_p0 || grant_p1) begin
                    state_nx = need_addr ? S_ADDR : S_CHAR;
                end
            end
            S_ADDR:  if (tx_last) state_nx = S_CHAR;
            S_CHAR:  if (tx_last) state_nx = S_IDLE;
            S_CLEAR: if (tx_last) state_nx = S_IDLE;
            default: state_nx = S_PWRUP;
        endcase
    end

    // Timing counter, init step, round-robin pointer, captured request and grant pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            init_idx  <= 2'd0;
            rr_p1     <= 1'b0;
            row_q     <= 1'b0;
            col_q     <= 4'd0;
            char_q    <= 8'd0;
            p0_ready  <= 1'b0;
            p1_ready  <= 1'b0;
            clr_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            p0_ready  <= grant_p0;
            p1_ready  <= grant_p1;
            clr_ready <= grant_clr;

            if (tx_last || pwr_last || (state == S_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if ((state == S_INIT) && tx_last) begin
                init_idx <= init_idx + 2'd1;
            end
            if (init_last) begin
                init_done <= 1'b1;
            end

            if (grant_p0) begin
                rr_p1 <= 1'b1;
            end else if (grant_p1) begin
                rr_p1 <= 1'b0;
            end

            if (grant_p0 || grant_p1) begin
                row_q  <= sel_row;
                col_q  <= sel_col;
                char_q <= sel_char;
            end
        end
    end

    // Bus byte for the current transaction; held constant for its whole length.
    always_comb begin
        lcd_data = 8'h00;
        case (state)
            S_INIT: begin
                case (init_idx)
                    2'd0:    lcd_data = 8'h3C;
                    2'd1:    lcd_data = 8'h0C;
                    2'd2:    lcd_data = 8'h06;
                    default: lcd_data = 8'h01;
                endcase
            end
            S_ADDR:  lcd_data = {1'b1, row_q, 2'b00, col_q};
            S_CHAR:  lcd_data = char_q;
            S_CLEAR: lcd_data = 8'h01;
            default: lcd_data = 8'h00;
        endcase
    end

    assign lcd_e  = in_tx && (cnt != '0) && (cnt <= E_LAST);
    assign lcd_rs = (state == S_CHAR);
    assign lcd_rw = 1'b0;
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// tb/tb_lcd_write_scheduler.sv - randomized self-checking bench for lcd_write_scheduler
module tb_lcd_write_scheduler;

    localparam int PWR    = 10;
    localparam int EH     = 2;
    localparam int CMDW   = 4;
    localparam int CLRW   = 8;
    localparam int TX_CMD = 1 + EH + CMDW;
    localparam int TX_CLR = 1 + EH + CLRW;
`ifdef LCD_CURSOR_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       p0_valid, p0_ready, p0_row;
    logic [3:0] p0_col;
    logic [7:0] p0_char;
    logic       p1_valid, p1_ready, p1_row;
    logic [3:0] p1_col;
    logic [7:0] p1_char;
    logic       clr_valid, clr_ready;
    logic       init_done, busy, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_write_scheduler #(
        .POWERUP_CYC (PWR),
        .E_HIGH_CYC  (EH),
        .CMD_WAIT_CYC(CMDW),
        .CLR_WAIT_CYC(CLRW),
        .CNT_W       (24)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .p0_valid (p0_valid),
        .p0_ready (p0_ready),
        .p0_row   (p0_row),
        .p0_col   (p0_col),
        .p0_char  (p0_char),
        .p1_valid (p1_valid),
        .p1_ready (p1_ready),
        .p1_row   (p1_row),
        .p1_col   (p1_col),
        .p1_char  (p1_char),
        .clr_valid(clr_valid),
        .clr_ready(clr_ready),
        .init_done(init_done),
        .busy     (busy),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] bus_q[$];
    logic [31:0] exp_bus[$];
    int          grant_q[$];
    int          exp_grant[$];
    int          svc_q[$];
    int          exp_svc[$];

    bit         m_rr;
    bit         m_cv;
    logic       m_row;
    logic [3:0] m_col;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_bus(input logic rs, input logic [7:0] d);
        return {7'd0, 1'b1, rs, d, 15'(EH)};
    endfunction

    // Bus monitor: one record per E pulse, grant log, and busy length per grant.
    bit         mon_prev_e;
    int         mon_ehi;
    logic       mon_rs;
    logic [7:0] mon_data;
    bit         mon_stable;
    bit         mon_svc_on;
    int         mon_svc_n;

    always @(negedge clk) begin
        if (rst) begin
            mon_prev_e = 1'b0;
            mon_svc_on = 1'b0;
            mon_ehi    = 0;
        end else begin
            if (lcd_e) begin
                if (!mon_prev_e) begin
                    mon_rs     = lcd_rs;
                    mon_data   = lcd_data;
                    mon_ehi    = 0;
                    mon_stable = 1'b1;
                end else if (lcd_rs !== mon_rs || lcd_data !== mon_data) begin
                    mon_stable = 1'b0;
                end
                mon_ehi++;
            end else if (mon_prev_e) begin
                if (lcd_rs !== mon_rs || lcd_data !== mon_data) mon_stable = 1'b0;
                bus_q.push_back({7'd0, mon_stable, mon_rs, mon_data, 15'(mon_ehi)});
            end
            mon_prev_e = lcd_e;
            if (mon_svc_on) begin
                if (busy) begin
                    mon_svc_n++;
                end else begin
                    svc_q.push_back(mon_svc_n);
                    mon_svc_on = 1'b0;
                end
            end
            if (p0_ready)  grant_q.push_back(0);
            if (p1_ready)  grant_q.push_back(1);
            if (clr_ready) grant_q.push_back(2);
            if (p0_ready || p1_ready || clr_ready) begin
                mon_svc_on = 1'b1;
                mon_svc_n  = 1;
            end
        end
    end

    task automatic model_reset();
        m_rr  = 1'b0;
        m_cv  = 1'b1;
        m_row = 1'b0;
        m_col = 4'd0;
    endtask

    // Expected bus traffic and service time for one grant, from the scheduling rules.
    task automatic model_grant(input int port, input logic row, input logic [3:0] col, input logic [7:0] ch);
        bit skip;
        exp_grant.push_back(port);
        if (port == 2) begin
            exp_bus.push_back(mk_bus(1'b0, 8'h01));
            exp_svc.push_back(TX_CLR);
            m_cv  = 1'b1;
            m_row = 1'b0;
            m_col = 4'd0;
        end else begin
            skip = TRACK && m_cv && (m_row == row) && (m_col == col);
            if (!skip) exp_bus.push_back(mk_bus(1'b0, 8'(128 + 64 * row + col)));
            exp_bus.push_back(mk_bus(1'b1, ch));
            exp_svc.push_back(skip ? TX_CMD : 2 * TX_CMD);
            m_rr  = (port == 0);
            m_row = row;
            m_cv  = (col != 4'd15);
            m_col = 4'((col + 1) % 16);
        end
    endtask

    task automatic compare_queues();
        check("grant_count", grant_q.size(), exp_grant.size());
        while (exp_grant.size() > 0)
            check("grant_order", (grant_q.size() > 0) ? grant_q.pop_front() : -1, exp_grant.pop_front());
        check("bus_count", bus_q.size(), exp_bus.size());
        while (exp_bus.size() > 0)
            check("bus_txn", (bus_q.size() > 0) ? bus_q.pop_front() : 32'hFFFF_FFFF, exp_bus.pop_front());
        check("svc_count", svc_q.size(), exp_svc.size());
        while (exp_svc.size() > 0)
            check("svc_cycles", (svc_q.size() > 0) ? svc_q.pop_front() : -1, exp_svc.pop_front());
        grant_q.delete();
        bus_q.delete();
        svc_q.delete();
    endtask

    task automatic do_reset_and_init();
        int n;
        rst = 1'b1;
        #1;
        check("reset_outputs",
              {16'd0, lcd_e, lcd_rs, lcd_rw, lcd_data, p0_ready, p1_ready, clr_ready, init_done, busy},
              32'h0000_0001);
        repeat (3) @(negedge clk);
        bus_q.delete();
        grant_q.delete();
        svc_q.delete();
        exp_bus.delete();
        exp_grant.delete();
        exp_svc.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (init_done) break;
            n++;
        end
        check("init_done_cycles", n, PWR + 3 * TX_CMD + TX_CLR);
        check("no_grant_during_init", grant_q.size(), 0);
        exp_bus.push_back(mk_bus(1'b0, 8'h3C));
        exp_bus.push_back(mk_bus(1'b0, 8'h0C));
        exp_bus.push_back(mk_bus(1'b0, 8'h06));
        exp_bus.push_back(mk_bus(1'b0, 8'h01));
        compare_queues();
        model_reset();
    endtask

    task automatic run_round(input bit rc, input bit r0, input bit r1,
                             input logic row0, input logic [3:0] col0, input logic [7:0] ch0,
                             input logic row1, input logic [3:0] col1, input logic [7:0] ch1);
        int n;
        if (rc) model_grant(2, 1'b0, 4'd0, 8'd0);
        if (r0 && r1) begin
            if (!m_rr) begin
                model_grant(0, row0, col0, ch0);
                model_grant(1, row1, col1, ch1);
            end else begin
                model_grant(1, row1, col1, ch1);
                model_grant(0, row0, col0, ch0);
            end
        end else if (r0) begin
            model_grant(0, row0, col0, ch0);
        end else if (r1) begin
            model_grant(1, row1, col1, ch1);
        end
        clr_valid = rc;
        p0_valid  = r0;
        p0_row    = row0;
        p0_col    = col0;
        p0_char   = ch0;
        p1_valid  = r1;
        p1_row    = row1;
        p1_col    = col1;
        p1_char   = ch1;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (p0_ready)  p0_valid  = 1'b0;
            if (p1_ready)  p1_valid  = 1'b0;
            if (clr_ready) clr_valid = 1'b0;
            if (!p0_valid && !p1_valid && !clr_valid && !busy) break;
        end
        check("all_served", {29'd0, clr_valid, p0_valid, p1_valid}, 32'd0);
        repeat (2) @(negedge clk);
        compare_queues();
    endtask

    initial begin
        logic       rc, r0, r1, row0, row1;
        logic [3:0] col0, col1;
        logic [7:0] ch0, ch1;
        int         n;

        rst       = 1'b0;
        clr_valid = 1'b0;
        p1_valid  = 1'b0;
        p1_row    = 1'b0;
        p1_col    = 4'd0;
        p1_char   = 8'd0;
        p0_valid  = 1'b1;
        p0_row    = 1'b1;
        p0_col    = 4'd3;
        p0_char   = 8'h35;
        model_reset();
        #2;
        do_reset_and_init();

        run_round(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 8'h35, 1'b0, 4'd0, 8'h00);
        run_round(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 8'h2B, 1'b0, 4'd0, 8'h00);
        repeat (2)
            run_round(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
        run_round(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 8'h41, 1'b0, 4'd9, 8'h42);
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
        run_round(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h58, 1'b0, 4'd0, 8'h00);
        run_round(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 8'h59, 1'b0, 4'd0, 8'h00);
        run_round(1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 8'h5A, 1'b0, 4'd0, 8'h00);

        for (int i = 0; i < 30; i++) begin
            rc   = ($urandom_range(0, 4) == 0);
            r0   = 1'($urandom_range(0, 1));
            r1   = 1'($urandom_range(0, 1));
            if (!rc && !r0 && !r1) r0 = 1'b1;
            row0 = $urandom_range(0, 1) ? m_row : 1'($urandom_range(0, 1));
            col0 = $urandom_range(0, 1) ? m_col : 4'($urandom_range(0, 15));
            row1 = $urandom_range(0, 1) ? m_row : 1'($urandom_range(0, 1));
            col1 = $urandom_range(0, 1) ? m_col : 4'($urandom_range(0, 15));
            ch0  = 8'($urandom);
            ch1  = 8'($urandom);
            run_round(rc, r0, r1, row0, col0, ch0, row1, col1, ch1);
        end

        p0_valid = 1'b1;
        p0_row   = 1'b1;
        p0_col   = 4'd2;
        p0_char  = 8'h77;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (p0_ready) p0_valid = 1'b0;
            if (lcd_e && lcd_rs) break;
            n++;
        end
        check("mid_char_e_high", {30'd0, lcd_e, lcd_rs}, 32'd3);
        p0_valid = 1'b0;
        do_reset_and_init();
        run_round(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h31, 1'b0, 4'd0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_write_scheduler.md
Name: lcd_write_scheduler

Overview:
Owns the HD44780 character-LCD bus and shares it between two character writers and a clear requester. Typical writers are the calculator expression line and the status/result line.
- Runs the power-up init sequence.
- Arbitrates requests.
- Generates rs/data/E timing.
- Tracks the cursor so a DDRAM set-address command is emitted only when needed.
Sits between calculator control logic and the LCD pins; replaces per-design hard-coded line1/line2 scan state machines.

Parameters:
POWERUP_CYC, 20000, clk cycles of idle wait after reset before the first command
E_HIGH_CYC, 12, clk cycles lcd_e is held high per transaction
CMD_WAIT_CYC, 2000, clk cycles with lcd_e low after each non-clear transaction
CLR_WAIT_CYC, 80000, clk cycles with lcd_e low after a clear-display (0x01) transaction
CNT_W, 24, width of the timing counter; must hold the largest of the above

Ports:
clk  in  1  system clock
rst  in  1  reset
p0_valid  in  1  port 0 write request
p0_ready  out  1  one-cycle grant pulse, port 0
p0_row  in  1  target row (0/1)
p0_col  in  4  target column 0..15
p0_char  in  8  ASCII code
p1_valid, p1_ready, p1_row, p1_col, p1_char  same as port 0, for port 1
clr_valid  in  1  clear-display request
clr_ready  out  1  one-cycle grant pulse, clear
init_done  out  1  high once the init sequence completes; stays high until reset
busy  out  1  high whenever the FSM is not in IDLE
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  tied 0 (write only)
lcd_data  out  8  LCD data bus

Interface rule: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset values:
  - All outputs 0, except busy = 1.
  - FSM in PWRUP; rr pointer favours p0; cursor_valid = 0.
- FSM states: PWRUP -> INIT -> IDLE -> {ADDR -> CHAR | CHAR | CLEAR} -> IDLE.
- PWRUP: wait POWERUP_CYC cycles, then go to INIT.
- INIT: issue commands 0x3C, 0x0C, 0x06, 0x01 in that order, all with rs = 0.
  - The 0x01 command uses CLR_WAIT_CYC.
  - On completion: init_done = 1, cursor = (0,0), cursor_valid = 1, go to IDLE.
- Bus transaction (every command or character):
  - 1 setup cycle: rs/data driven, e = 0.
  - E_HIGH_CYC cycles with e = 1.
  - Wait cycles with e = 0.
  - rs and data are held stable for the whole transaction.
  - Total length: 1 + E_HIGH_CYC + wait.
- IDLE arbitration, sampled every cycle:
  - Priority: clr_valid first, then round-robin between p0 and p1.
  - After a grant to pX, the other port has priority next time.
  - A lone requester is always granted.
- Grant:
  - The matching *_ready is high for exactly the one cycle after the sampling edge.
  - row/col/char are captured at the sampling edge.
  - The requester must hold valid and its fields stable until it sees ready.
  - No grants are issued before init_done or outside IDLE.
- Character grant:
  - If cursor_valid and cursor == (row,col): go straight to CHAR.
  - Otherwise go to ADDR, which issues rs = 0, data = 0x80 | row<<6 | col, then CHAR.
  - CHAR issues rs = 1, data = char.
  - Then col = col + 1. If the written col was 15, cursor_valid = 0, which forces an address command on the next write.
- Clear grant: CLEAR issues 0x01 with CLR_WAIT_CYC, then cursor = (0,0), cursor_valid = 1.
- Service times back to IDLE: character without address 1 + E_HIGH_CYC + CMD_WAIT_CYC; with address twice that.
- Requests are never dropped; unserved ports keep waiting.
- Reset mid-operation: immediate return to reset values, lcd_e drops asynchronously, full init re-runs, any in-flight request is lost.

Optional Feature:
LCD_CURSOR_TRACK_EN:
- Defined: cursor tracking and address skipping as described above.
- Undefined: no cursor state; every character grant passes through ADDR, so each write is two transactions.

Test Plan:
- Reset, sample params (POWERUP 10, E 2, CMD 4, CLR 8) -> lcd_data sequence 0x3C, 0x0C, 0x06, 0x01 (rs = 0), each with 2-cycle E high; init_done rises after the 0x01 wait; p0_valid held during init gets no p0_ready until then.
- p0 write (1, 3, 0x35) -> 0xC3 rs = 0, then 0x35 rs = 1; p0_ready exactly 1 cycle; busy high 14 cycles.
- Follow-up p0 (1, 4, 0x2B) -> only 0x2B rs = 1, no address. With macro undefined -> 0xC4 then 0x2B.
- p0 and p1 valid continuously -> grants alternate p0, p1, p0, p1; clr_valid asserted alongside -> clear granted next, 0x01 with 8 wait cycles, then the next write to (0,0) skips address.
- Writes to (0,15) then (0,15) again -> second write re-emits 0x8F.
- Assert rst while lcd_e = 1 mid-CHAR -> lcd_e = 0 immediately, init_done = 0, full init sequence repeats.
